// File: rtl/fetch_pkg.sv
// Constants and state encoding shared by the fetch, decode and execute stages.
package fetch_pkg;
    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter: redirect target, sequential step, or hold.
module fetch_pc_gen
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_advance,
    output logic [XLEN-1:0] o_pc
);
    logic [XLEN-1:0] r_pc;

    // Redirect wins over advance; the add wraps modulo 2^XLEN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_redirect_pc;
        end else if (i_advance) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding imem requests, stall hold buffer,
// redirect flush, and the IR2/PC2 pipeline registers feeding decode.
module fetch_stage
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] ir2_output,
    output logic [XLEN-1:0] pc2_output,
    output logic            valid2
);
    fetch_state_t    r_state;
    logic            r_req;
    logic            r_drop;
    logic [XLEN-1:0] r_hold;
    logic [XLEN-1:0] r_ir2;
    logic [XLEN-1:0] r_pc2;
    logic            r_valid2;

    logic [XLEN-1:0] w_pc;
    logic            w_accept;
    logic            w_load_mem;
    logic            w_load_hold;
    logic            w_advance;

    // Handshake: a request is accepted on an edge where imem_req & imem_ready;
    // imem_addr is held until then, and exactly one imem_rvalid pulse follows.
    assign w_accept    = r_req & imem_ready;
    assign w_load_mem  = (r_state == FS_WAIT) & imem_rvalid & ~r_drop & ~stall & ~redirect;
    assign w_load_hold = (r_state == FS_HOLD) & ~stall & ~redirect;
    assign w_advance   = w_load_mem | w_load_hold;

    fetch_pc_gen u_pc_gen (
        .clk           (clk),
        .reset         (reset),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_advance     (w_advance),
        .o_pc          (w_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= FS_REQ;
            r_req    <= 1'b0;
            r_drop   <= 1'b0;
            r_hold   <= '0;
            r_ir2    <= NOP_INSTR;
            r_pc2    <= '0;
            r_valid2 <= 1'b0;
        end else if (redirect) begin
            r_ir2    <= NOP_INSTR;
            r_valid2 <= 1'b0;
            case (r_state)
                FS_REQ: begin
                    // An old request accepted on this edge still owes a response.
                    if (w_accept) begin
                        r_state <= FS_WAIT;
                        r_drop  <= 1'b1;
                        r_req   <= 1'b0;
                    end else begin
                        r_req   <= 1'b1;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= FS_REQ;
                        r_drop  <= 1'b0;
                        r_req   <= 1'b1;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= FS_REQ;
                    r_drop  <= 1'b0;
                    r_req   <= 1'b1;
                end
            endcase
        end else begin
            case (r_state)
                FS_REQ: begin
                    if (w_accept) begin
                        r_state <= FS_WAIT;
                        r_req   <= 1'b0;
                    end else begin
                        r_req   <= 1'b1;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= FS_REQ;
                            r_req   <= 1'b1;
                        end else if (!stall) begin
                            r_ir2    <= imem_rdata;
                            r_pc2    <= w_pc;
                            r_valid2 <= 1'b1;
                            r_state  <= FS_REQ;
                            r_req    <= 1'b1;
                        end else begin
                            r_hold  <= imem_rdata;
                            r_state <= FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (!stall) begin
                        r_ir2    <= r_hold;
                        r_pc2    <= w_pc;
                        r_valid2 <= 1'b1;
                        r_state  <= FS_REQ;
                        r_req    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= FS_REQ;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = w_pc;
    assign ir2_output = r_ir2;
    assign pc2_output = r_pc2;
    assign valid2     = r_valid2;
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the program counter and issues one request at a time to instruction memory.
- Registers each returned instruction and its address into ir2_output / pc2_output, which the decode stage consumes.
- Honours a stall from hazard control, and a taken-branch redirect using the decode stage's branch-address output.

Parameters:
- XLEN, 32, datapath/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0000, bubble encoding (matches the decode-stage nop)
- PC_STEP, 4, byte increment per sequential fetch

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (reset=0 resets)
- imem_req  out  1  request valid; held until imem_ready
- imem_addr  out  XLEN  fetch address; stable while imem_req=1
- imem_ready  in  1  memory accepts request this cycle (req&ready = handshake)
- imem_rvalid  in  1  read data valid; one pulse per accepted request, at least 1 cycle after acceptance
- imem_rdata  in  XLEN  instruction word
- stall  in  1  decode cannot accept; hold IR2/PC2
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  XLEN  target (decode stage branchaddress_input)
- ir2_output  out  XLEN  instruction to decode
- pc2_output  out  XLEN  address of ir2_output
- valid2  out  1  ir2_output holds a real instruction (0 = bubble)

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC, state=REQ, imem_req=0, ir2_output=NOP_INSTR, pc2_output=0, valid2=0, drop=0, hold buffer cleared.
  - imem_req rises on the first clock edge with reset=1.
  - Reset asserted mid-transaction abandons it; a late rvalid after reset release is ignored (drop is set when leaving reset with a request in flight is impossible, since the memory is reset on the same net).
- FSM states:
  - REQ: imem_req=1, imem_addr=pc. On imem_ready go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - If drop=1, discard the data, clear drop, go to REQ.
    - Else if stall=0, load ir2_output=imem_rdata, pc2_output=pc, valid2=1, pc=pc+PC_STEP, go to REQ.
    - Else (stall=1), store the word in a hold buffer and go to HOLD.
  - HOLD: when stall=0, load IR2/PC2/valid2 from the hold buffer, pc+=PC_STEP, go to REQ.
- Stall: while stall=1, ir2_output, pc2_output and valid2 are unchanged. Stall does not block issuing a request in REQ.
- Redirect (highest priority, any state), on the same edge:
  - pc=redirect_pc.
  - ir2_output=NOP_INSTR, valid2=0. Flush overrides stall.
  - REQ: stay in REQ; the next cycle's imem_addr=redirect_pc. If imem_ready was high that same cycle, the accepted old request is tracked: set drop=1 and go to WAIT.
  - WAIT: drop=1 and stay in WAIT, unless rvalid arrives on that same edge, in which case discard it and go to REQ.
  - HOLD: discard the buffer and go to REQ.
- Simultaneous redirect and rvalid: the data is discarded, never written to IR2.
- Arithmetic: pc+PC_STEP is modulo 2^XLEN (0xFFFFFFFC wraps to 0x00000000); no overflow flag.
- imem_addr is always pc and is word-aligned whenever redirect_pc is aligned. The alignment of redirect_pc is not checked.
- Latency and throughput:
  - With ready=1 and rvalid one cycle after acceptance: IR2 updates 2 cycles after imem_req first rises.
  - Steady throughput is one instruction per 2 cycles (single outstanding request by design).
- At most one outstanding request at any time; imem_req is never asserted in WAIT or HOLD.

Decomposition:
- Shared package (also used by decode/execute):
  - XLEN
  - NOP_INSTR
  - PC_STEP
  - RESET_PC
  - fetch state enumeration {REQ, WAIT, HOLD}
- One natural sub-module, fetch_pc_gen: holds the PC register, selects among hold / pc+PC_STEP / redirect_pc, and exposes pc.
- FSM, drop flag, hold buffer and IR2/PC2 registers stay in fetch_stage.

Test Plan:
- Reset release, memory ready=1, rvalid 1 cycle later returning 0x00A00093 / 0x00200113 -> imem_addr 0x0, then 0x4. IR2 shows 0x00A00093 with pc2=0x0, then 0x00200113 with pc2=0x4; valid2=1.
- stall=1 for 3 cycles while rvalid returns 0x00308193 for pc 0x8 -> IR2/pc2 unchanged during the stall. One cycle after stall=0, IR2=0x00308193, pc2=0x8, next imem_addr=0xC.
- redirect=1, redirect_pc=0x40 while in WAIT for pc 0x10 -> ir2=0, valid2=0. Data returned for 0x10 is discarded; the next imem_addr is 0x40, and the resulting IR2 has pc2=0x40.
- redirect and imem_rvalid on the same edge, with redirect_pc=0x80 -> data never appears on IR2; valid2=0; next imem_addr=0x80.
- redirect_pc=0xFFFFFFFC, returned word 0x00000013 -> pc2=0xFFFFFFFC, next imem_addr wraps to 0x00000000.
- reset=0 asserted asynchronously mid-WAIT -> outputs go to reset values immediately. After release, imem_addr=RESET_PC and no stale IR2 update occurs.
